// File: rtl/xafifo_wr_arbiter_if.sv
// Requester/FIFO-side bundle for the XAFifo write-port arbiter.
// master: the arbiter; slave: the requesters and FIFO it connects to.
interface xafifo_wr_arbiter_if #(
  parameter int N  = 4,
  parameter int DW = 8
);
  localparam int OW = $clog2(N);

  logic [N-1:0]    req_vld;
  logic [N-1:0]    req_last;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_rdy;
  logic [OW-1:0]   owner;
  logic            busy;
  logic            fifo_we;
  logic [DW-1:0]   fifo_din;
  logic            fifo_full_n;

  modport master (
    input  req_vld, req_last, req_data, fifo_full_n,
    output req_rdy, owner, busy, fifo_we, fifo_din
  );

  modport slave (
    output req_vld, req_last, req_data, fifo_full_n,
    input  req_rdy, owner, busy, fifo_we, fifo_din
  );
endinterface

// File: rtl/xafifo_wr_arbiter.sv
// Round-robin arbiter sharing the XAFifo write port among N requesters.
// Define XAFIFO_ARB_PKT_LOCK_EN to hold the grant until a packet's last beat.
module xafifo_wr_arbiter #(
  parameter int N  = 4,
  parameter int DW = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  xafifo_wr_arbiter_if.master   bus
);
  localparam int OW = $clog2(N);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [OW-1:0] rr_ptr_q, rr_ptr_d;
  logic [OW-1:0] owner_q, owner_d;

  logic [OW-1:0] scanIdx;
  logic [OW-1:0] pickIdx;
  logic          pickFound;
  logic          fifoWe;
  logic [N-1:0]  reqRdy;
  logic          lastBeat;

  // Explicit wrap so N need not be a power of two.
  function automatic logic [OW-1:0] modInc(input logic [OW-1:0] v);
    if (v == OW'(N - 1)) return '0;
    else                 return v + 1'b1;
  endfunction

`ifdef XAFIFO_ARB_PKT_LOCK_EN
  assign lastBeat = bus.req_last[owner_q];
`else
  logic unusedLast;
  assign lastBeat   = 1'b1;
  assign unusedLast = ^bus.req_last;
`endif

  always_comb begin
    scanIdx   = rr_ptr_q;
    pickIdx   = rr_ptr_q;
    pickFound = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!pickFound && bus.req_vld[scanIdx]) begin
        pickFound = 1'b1;
        pickIdx   = scanIdx;
      end
      scanIdx = modInc(scanIdx);
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    fifoWe   = 1'b0;
    reqRdy   = '0;
    case (state_q)
      IDLE: begin
        if (pickFound) begin
          owner_d = pickIdx;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (bus.fifo_full_n) reqRdy = {{(N-1){1'b0}}, 1'b1} << owner_q;
        fifoWe = bus.req_vld[owner_q] & bus.fifo_full_n;
        if (fifoWe && lastBeat) begin
          state_d  = IDLE;
          rr_ptr_d = modInc(owner_q);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
    end
  end

  assign bus.busy     = (state_q == BUSY);
  assign bus.owner    = owner_q;
  assign bus.fifo_we  = fifoWe;
  assign bus.req_rdy  = reqRdy;
  assign bus.fifo_din = bus.req_data[owner_q*DW +: DW];
endmodule

// File: tb/tb_xafifo_wr_arbiter.sv
// Self-checking bench for xafifo_wr_arbiter against a cycle-level grant model.
// Honours XAFIFO_ARB_PKT_LOCK_EN for both the model and the directed expectations.
module tb_xafifo_wr_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int OW = $clog2(N);
`ifdef XAFIFO_ARB_PKT_LOCK_EN
  localparam bit LockEn = 1'b1;
  int expLockOwners[8] = '{1, 1, 1, 1, 3, 3, 0, 0};
  int expLockWe[11]    = '{0, 1, 1, 1, 1, 0, 1, 1, 0, 1, 1};
`else
  localparam bit LockEn = 1'b0;
  int expLockOwners[8] = '{1, 3, 0, 1, 3, 0, 1, 1};
  int expLockWe[11]    = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
`endif

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  xafifo_wr_arbiter_if #(.N(N), .DW(DW)) bus ();
  xafifo_wr_arbiter #(.N(N), .DW(DW)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  int checks   = 0;
  int failures = 0;

  // Requester-side stimulus state
  int            pktLeft[N];
  logic [DW-1:0] curData[N];
  int            refillLen  = 0;
  bit            randRefill = 1'b0;
  bit            randFull   = 1'b0;
  bit            fullN      = 1'b1;

  // Reference model: grant holder, busy flag, round-robin start point
  int mBusy = 0, mOwner = 0, mPtr = 0;

  int            ownerLog[$];
  logic [DW-1:0] dataLog[$];
  logic [DW-1:0] sentLog[$];
  bit            weLog[$];

  task automatic driveInputs();
    logic [N-1:0]    v, l;
    logic [N*DW-1:0] d;
    for (int j = 0; j < N; j++) begin
      v[j]          = (pktLeft[j] > 0);
      l[j]          = (pktLeft[j] == 1);
      d[j*DW +: DW] = curData[j];
    end
    bus.req_vld     = v;
    bus.req_last    = l;
    bus.req_data    = d;
    bus.fifo_full_n = fullN;
  endtask

  task automatic newBeat(input int j);
    curData[j] = DW'($urandom);
    sentLog.push_back(curData[j]);
  endtask

  task automatic startPkt(input int j, input int len);
    pktLeft[j] = len;
    newBeat(j);
  endtask

  task automatic clearLogs();
    ownerLog.delete();
    dataLog.delete();
    sentLog.delete();
    weLog.delete();
  endtask

  function automatic bit anyPending();
    for (int j = 0; j < N; j++) if (pktLeft[j] > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic modelReset();
    mBusy  = 0;
    mOwner = 0;
    mPtr   = 0;
  endtask

  // One clock: compare at negedge, advance model and requesters just after posedge.
  task automatic step();
    logic [N-1:0] expRdy;
    bit           expWe;
    int           acc;
    int           j;
    bit           found;
    @(negedge clk);
    acc    = -1;
    expWe  = 1'b0;
    expRdy = '0;
    if (mBusy != 0) begin
      expWe = (pktLeft[mOwner] > 0) && fullN;
      if (fullN) expRdy[mOwner] = 1'b1;
    end
    checks++;
    if (bus.busy !== (mBusy != 0)) begin
      failures++;
      $display("FAIL busy @%0t: got %b expected %b", $time, bus.busy, (mBusy != 0));
    end
    checks++;
    if (bus.fifo_we !== expWe) begin
      failures++;
      $display("FAIL fifo_we @%0t: got %b expected %b", $time, bus.fifo_we, expWe);
    end
    checks++;
    if (bus.req_rdy !== expRdy) begin
      failures++;
      $display("FAIL req_rdy @%0t: got %b expected %b", $time, bus.req_rdy, expRdy);
    end
    if (mBusy != 0) begin
      checks++;
      if (bus.owner !== OW'(mOwner)) begin
        failures++;
        $display("FAIL owner @%0t: got %0d expected %0d", $time, bus.owner, mOwner);
      end
    end
    if (expWe) begin
      checks++;
      if (bus.fifo_din !== curData[mOwner]) begin
        failures++;
        $display("FAIL fifo_din @%0t: got %h expected %h", $time, bus.fifo_din, curData[mOwner]);
      end
    end
    if (bus.fifo_we === 1'b1) begin
      ownerLog.push_back(int'(bus.owner));
      dataLog.push_back(bus.fifo_din);
    end
    weLog.push_back(bus.fifo_we === 1'b1);
    if (rstn) begin
      if (mBusy == 0) begin
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          j = (mPtr + k) % N;
          if (!found && pktLeft[j] > 0) begin
            found  = 1'b1;
            mOwner = j;
            mBusy  = 1;
          end
        end
      end else if (expWe) begin
        acc = mOwner;
        if (!LockEn || pktLeft[mOwner] == 1) begin
          mBusy = 0;
          mPtr  = (mOwner + 1) % N;
        end
      end
    end
    @(posedge clk);
    #1;
    if (acc >= 0) begin
      pktLeft[acc]--;
      if (pktLeft[acc] > 0)  newBeat(acc);
      else if (refillLen > 0) startPkt(acc, refillLen);
    end
    if (randRefill)
      for (int r = 0; r < N; r++)
        if (pktLeft[r] == 0 && $urandom_range(0, 2) == 0) startPkt(r, int'($urandom_range(1, 4)));
    if (randFull) fullN = ($urandom_range(0, 3) != 0);
    driveInputs();
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (anyPending() && c < 300) begin
      step();
      c++;
    end
    step();
    step();
    checks++;
    if (anyPending()) begin
      failures++;
      $display("FAIL drain_timeout: got pending=1 expected pending=0");
    end
  endtask

  task automatic test_reset();
    rstn  = 1'b0;
    fullN = 1'b1;
    refillLen = 1;
    for (int j = 0; j < N; j++) startPkt(j, 1);
    driveInputs();
    modelReset();
    #3;
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++;
    if (bus.owner !== '0) begin failures++; $display("FAIL reset_owner: got %0d expected 0", bus.owner); end
    checks++;
    if (bus.fifo_we !== 1'b0) begin failures++; $display("FAIL reset_we: got %b expected 0", bus.fifo_we); end
    checks++;
    if (bus.req_rdy !== '0) begin failures++; $display("FAIL reset_rdy: got %b expected 0", bus.req_rdy); end
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    clearLogs();
  endtask

  task automatic test_round_robin();
    repeat (10) step();
    checks++;
    if (ownerLog.size() < 5) begin
      failures++;
      $display("FAIL rr_count: got %0d writes expected >=5", ownerLog.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (ownerLog[i] != i % N) begin
          failures++;
          $display("FAIL rr_order[%0d]: got %0d expected %0d", i, ownerLog[i], i % N);
        end
      end
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (weLog[i] != bit'(i % 2)) begin
        failures++;
        $display("FAIL rr_we_cadence[%0d]: got %b expected %b", i, weLog[i], bit'(i % 2));
      end
    end
    refillLen = 0;
    drain();
  endtask

  task automatic test_packet_stall();
    clearLogs();
    startPkt(2, 3);
    fullN = 1'b1;
    driveInputs();
    step();
    step();
`ifndef XAFIFO_ARB_PKT_LOCK_EN
    step();
`endif
    for (int s = 0; s < 5; s++) begin
      fullN = 1'b0;
      driveInputs();
      #1;
      checks++;
      if (bus.fifo_we !== 1'b0) begin failures++; $display("FAIL stall_we[%0d]: got %b expected 0", s, bus.fifo_we); end
      checks++;
      if (bus.req_rdy !== '0) begin failures++; $display("FAIL stall_rdy[%0d]: got %b expected 0", s, bus.req_rdy); end
      checks++;
      if (bus.owner !== OW'(2)) begin failures++; $display("FAIL stall_owner[%0d]: got %0d expected 2", s, bus.owner); end
      step();
    end
    fullN = 1'b1;
    driveInputs();
    drain();
    checks++;
    if (dataLog.size() != 3) begin
      failures++;
      $display("FAIL stall_beats: got %0d expected 3", dataLog.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (dataLog[i] !== sentLog[i] || ownerLog[i] != 2) begin
          failures++;
          $display("FAIL stall_data[%0d]: got %h/src%0d expected %h/src2", i, dataLog[i], ownerLog[i], sentLog[i]);
        end
      end
    end
    clearLogs();
    for (int j = 0; j < N; j++) startPkt(j, 1);
    driveInputs();
    drain();
    checks++;
    if (ownerLog.size() != 4) begin
      failures++;
      $display("FAIL ptr_after_pkt_count: got %0d expected 4", ownerLog.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (ownerLog[i] != (3 + i) % N) begin
          failures++;
          $display("FAIL ptr_after_pkt[%0d]: got %0d expected %0d", i, ownerLog[i], (3 + i) % N);
        end
      end
    end
  endtask

  task automatic test_lock();
    startPkt(0, 1);
    driveInputs();
    drain();
    clearLogs();
    startPkt(1, 4);
    startPkt(0, 2);
    startPkt(3, 2);
    driveInputs();
    drain();
    checks++;
    if (ownerLog.size() != 8) begin
      failures++;
      $display("FAIL lock_count: got %0d expected 8", ownerLog.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (ownerLog[i] != expLockOwners[i]) begin
          failures++;
          $display("FAIL lock_order[%0d]: got %0d expected %0d", i, ownerLog[i], expLockOwners[i]);
        end
      end
    end
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (weLog[i] != bit'(expLockWe[i])) begin
        failures++;
        $display("FAIL lock_we[%0d]: got %b expected %0d", i, weLog[i], expLockWe[i]);
      end
    end
  endtask

  task automatic test_reset_midpacket();
    clearLogs();
    startPkt(2, 3);
    driveInputs();
    step();
    step();
`ifndef XAFIFO_ARB_PKT_LOCK_EN
    step();
`endif
    #2;
    checks++;
    if (bus.busy !== 1'b1) begin failures++; $display("FAIL midrst_pre_busy: got %b expected 1", bus.busy); end
    rstn = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b expected 0", bus.busy); end
    checks++;
    if (bus.fifo_we !== 1'b0) begin failures++; $display("FAIL midrst_we: got %b expected 0", bus.fifo_we); end
    checks++;
    if (bus.req_rdy !== '0) begin failures++; $display("FAIL midrst_rdy: got %b expected 0", bus.req_rdy); end
    modelReset();
    for (int j = 0; j < N; j++) startPkt(j, 1);
    driveInputs();
    step();
    rstn = 1'b1;
    clearLogs();
    drain();
    checks++;
    if (ownerLog.size() != 4) begin
      failures++;
      $display("FAIL midrst_count: got %0d expected 4", ownerLog.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (ownerLog[i] != i) begin
          failures++;
          $display("FAIL midrst_order[%0d]: got %0d expected %0d", i, ownerLog[i], i);
        end
      end
    end
  endtask

  task automatic test_random();
    clearLogs();
    randRefill = 1'b1;
    randFull   = 1'b1;
    repeat (1500) step();
    randRefill = 1'b0;
    randFull   = 1'b0;
    fullN      = 1'b1;
    driveInputs();
    drain();
    checks++;
    if (dataLog.size() != sentLog.size()) begin
      failures++;
      $display("FAIL random_beats: got %0d writes expected %0d", dataLog.size(), sentLog.size());
    end
  endtask

  initial begin
    for (int j = 0; j < N; j++) begin
      pktLeft[j] = 0;
      curData[j] = '0;
    end
    driveInputs();
    test_reset();
    test_round_robin();
    test_packet_stall();
    test_lock();
    test_reset_midpacket();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
